// File: rtl/p1_action_sequencer.sv
// Player 1 per-frame action controller: arbitrates hit/punch/kick/walk requests
// into one wall-clamped X motion per video frame, with hitbox flag and attack cooldown.
module p1_action_sequencer #(
    parameter int BOUND_X_MIN = 7,
    parameter int BOUND_X_MAX = 632,
    parameter int COOLDOWN    = 4
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               Punch,
    input  logic               Kick,
    input  logic               Walk_L,
    input  logic               Walk_R,
    input  logic               Hit,
    input  logic               Hit_Dir,
    input  logic signed [31:0] Xpos,
    output logic signed [31:0] Ball_X_Motion,
    output logic [2:0]         Action,
    output logic               Busy,
    output logic               Hit_Active
);

    typedef enum logic [2:0] {
        A_IDLE  = 3'd0,
        A_WALK  = 3'd1,
        A_PUNCH = 3'd2,
        A_KICK  = 3'd3,
        A_KNOCK = 3'd4,
        A_COOL  = 3'd5
    } action_t;

    localparam logic signed [31:0] L_MIN_X   = 32'(BOUND_X_MIN);
    localparam logic signed [31:0] L_MAX_X   = 32'(BOUND_X_MAX);
    localparam logic [7:0]         COOL_LOAD = 8'(COOLDOWN);
    localparam logic [3:0]         STEP_DONE = 4'd15;

    action_t            r_action;
    action_t            w_nextAction;
    logic [3:0]         r_step;
    logic [3:0]         w_idx;
    logic [3:0]         w_nextStep;
    logic [3:0]         w_finalStep;
    logic [7:0]         r_cnt;
    logic [7:0]         w_nextCnt;
    logic               r_dir;
    logic               w_nextDir;
    logic               r_hit;
    logic               w_nextHit;
    logic               w_takeArb;
    logic               w_profile;
    logic               w_clamped;
    logic signed [31:0] r_motion;
    logic signed [31:0] w_cand;
    logic signed [31:0] w_sum;
    logic signed [31:0] w_clampedMotion;
    logic signed [31:0] w_walkMotion;

    function automatic logic [3:0] profLen(input action_t a);
        return (a == A_PUNCH) ? 4'd6 : 4'd8;
    endfunction

    // Fixed per-step motion tables; knockback magnitude takes its sign from the latched direction.
    function automatic logic signed [31:0] profStep(input action_t a, input logic [3:0] idx,
                                                    input logic dir);
        logic signed [31:0] m;
        m = 32'sd0;
        case (a)
            A_PUNCH: begin
                case (idx[3:1])
                    3'd0:    m = -32'sd7;
                    3'd1:    m = -32'sd5;
                    default: m = -32'sd3;
                endcase
            end
            A_KICK: m = (idx[3:2] == 2'd0) ? -32'sd4 : 32'sd0;
            A_KNOCK: begin
                case (idx[3:1])
                    3'd0:    m = 32'sd6;
                    3'd1:    m = 32'sd4;
                    3'd2:    m = 32'sd2;
                    default: m = 32'sd1;
                endcase
                if (!dir) m = -m;
            end
            default: m = 32'sd0;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_action <= A_IDLE;
            r_step   <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_motion <= '0;
            r_hit    <= 1'b0;
        end else if (frame_tick) begin
            r_action <= w_nextAction;
            r_step   <= w_finalStep;
            r_cnt    <= w_nextCnt;
            r_dir    <= w_nextDir;
            r_motion <= w_clampedMotion;
            r_hit    <= w_nextHit;
        end
    end

    assign w_walkMotion = (Walk_L && !Walk_R) ? -32'sd2 :
                          (Walk_R && !Walk_L) ?  32'sd2 : 32'sd0;

    // A finished knockback or an expired cooldown re-arbitrates on the same tick as IDLE would.
    always_comb begin
        w_nextAction = r_action;
        w_nextCnt    = r_cnt;
        w_nextDir    = r_dir;
        w_idx        = r_step;
        w_takeArb    = 1'b0;
        if (Hit) begin
            w_nextAction = A_KNOCK;
            w_nextDir    = Hit_Dir;
            w_nextCnt    = '0;
            w_idx        = '0;
        end else begin
            case (r_action)
                A_PUNCH, A_KICK: begin
                    if (r_step >= profLen(r_action)) begin
                        w_nextAction = A_COOL;
                        w_nextCnt    = COOL_LOAD;
                    end
                end
                A_KNOCK: w_takeArb = (r_step >= profLen(A_KNOCK));
                A_COOL: begin
                    if (r_cnt > 8'd1) w_nextCnt = r_cnt - 8'd1;
                    else              w_takeArb = 1'b1;
                end
                default: w_takeArb = 1'b1;
            endcase
            if (w_takeArb) begin
                w_nextCnt = '0;
                w_idx     = '0;
                if (Punch)                 w_nextAction = A_PUNCH;
                else if (Kick)             w_nextAction = A_KICK;
                else if (Walk_L != Walk_R) w_nextAction = A_WALK;
                else                       w_nextAction = A_IDLE;
            end
        end
    end

    // A clamped attack step parks the index past the table so the next tick ends the profile.
    always_comb begin
        w_profile = (w_nextAction == A_PUNCH) || (w_nextAction == A_KICK) ||
                    (w_nextAction == A_KNOCK);
        w_cand     = 32'sd0;
        w_nextStep = '0;
        if (w_profile) begin
            w_cand     = profStep(w_nextAction, w_idx, w_nextDir);
            w_nextStep = w_idx + 4'd1;
        end else if ((w_nextAction == A_WALK) || (w_nextAction == A_COOL)) begin
            w_cand = w_walkMotion;
        end
        w_sum           = Xpos + w_cand;
        w_clamped       = 1'b0;
        w_clampedMotion = w_cand;
        if (w_sum < L_MIN_X) begin
            w_clampedMotion = L_MIN_X - Xpos;
            w_clamped       = 1'b1;
        end else if (w_sum > L_MAX_X) begin
            w_clampedMotion = L_MAX_X - Xpos;
            w_clamped       = 1'b1;
        end
        w_finalStep = (w_clamped && w_profile) ? STEP_DONE : w_nextStep;
        w_nextHit   = ((w_nextAction == A_PUNCH) && ((w_idx == 4'd2) || (w_idx == 4'd3))) ||
                      ((w_nextAction == A_KICK)  && ((w_idx == 4'd4) || (w_idx == 4'd5)));
    end

    assign Ball_X_Motion = r_motion;
    assign Action        = r_action;
    assign Busy          = (r_action == A_PUNCH) || (r_action == A_KICK) || (r_action == A_KNOCK);
    assign Hit_Active    = r_hit;

endmodule

// File: tb/tb_p1_action_sequencer.sv
// Bench for p1_action_sequencer: queue-based frame model, per-cycle compare,
// directed frame scenarios with literal pins, then randomized traffic.
module tb_p1_action_sequencer;

    localparam int MIN_X    = 7;
    localparam int MAX_X    = 632;
    localparam int COOLDOWN = 4;

    logic               clk = 1'b0;
    logic               Reset_n;
    logic               frame_tick;
    logic               Punch;
    logic               Kick;
    logic               Walk_L;
    logic               Walk_R;
    logic               Hit;
    logic               Hit_Dir;
    logic signed [31:0] Xpos;
    logic signed [31:0] Ball_X_Motion;
    logic [2:0]         Action;
    logic               Busy;
    logic               Hit_Active;

    p1_action_sequencer #(
        .BOUND_X_MIN(MIN_X),
        .BOUND_X_MAX(MAX_X),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk),
        .Reset_n(Reset_n),
        .frame_tick(frame_tick),
        .Punch(Punch),
        .Kick(Kick),
        .Walk_L(Walk_L),
        .Walk_R(Walk_R),
        .Hit(Hit),
        .Hit_Dir(Hit_Dir),
        .Xpos(Xpos),
        .Ball_X_Motion(Ball_X_Motion),
        .Action(Action),
        .Busy(Busy),
        .Hit_Active(Hit_Active)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    int punchProf[6] = '{-7, -7, -5, -5, -3, -3};
    bit punchHit[6]  = '{0, 0, 1, 1, 0, 0};
    int kickProf[8]  = '{-4, -4, -4, -4, 0, 0, 0, 0};
    bit kickHit[8]   = '{0, 0, 0, 0, 1, 1, 0, 0};
    int knockMag[8]  = '{6, 6, 4, 4, 2, 2, 1, 1};

    int mAct;
    int coolLeft;
    int motionQ[$];
    bit hitQ[$];

    int expMotion = 0;
    int expAct = 0;
    bit expHit = 1'b0;
    int nxtMotion = 0;
    int nxtAct = 0;
    bit nxtHit = 1'b0;
    bit checkEn = 1'b0;
    int x;

    task automatic compareInt(input string name, input int got, input int want);
        nCompared++;
        if (got != want) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic pinCheck(input string name, input int dutVal, input int modelVal, input int lit);
        compareInt({name, "_dut"}, dutVal, lit);
        compareInt({name, "_model"}, modelVal, lit);
    endtask

    task automatic modelReset();
        mAct     = 0;
        coolLeft = 0;
        motionQ.delete();
        hitQ.delete();
        nxtMotion = 0;
        nxtAct    = 0;
        nxtHit    = 1'b0;
    endtask

    // One frame of the player's behaviour, expressed as a queue of remaining profile frames.
    task automatic modelTick(input bit p, input bit k, input bit wl, input bit wr,
                             input bit h, input bit hd, input int xv);
        int m;
        int walkM;
        int sum;
        bit hitA;
        bit arb;
        bit prof;
        walkM = (wl && !wr) ? -2 : ((wr && !wl) ? 2 : 0);
        arb   = 1'b0;
        prof  = 1'b0;
        hitA  = 1'b0;
        if (h) begin
            mAct = 4;
            motionQ.delete();
            hitQ.delete();
            foreach (knockMag[i]) begin
                motionQ.push_back(hd ? knockMag[i] : -knockMag[i]);
                hitQ.push_back(1'b0);
            end
        end else if ((mAct == 2 || mAct == 3) && motionQ.size() == 0) begin
            mAct     = 5;
            coolLeft = COOLDOWN - 1;
        end else if (mAct == 4 && motionQ.size() == 0) begin
            arb = 1'b1;
        end else if (mAct == 5) begin
            if (coolLeft > 0) coolLeft--;
            else              arb = 1'b1;
        end else if (mAct == 0 || mAct == 1) begin
            arb = 1'b1;
        end
        if (arb) begin
            motionQ.delete();
            hitQ.delete();
            if (p) begin
                mAct = 2;
                foreach (punchProf[i]) begin
                    motionQ.push_back(punchProf[i]);
                    hitQ.push_back(punchHit[i]);
                end
            end else if (k) begin
                mAct = 3;
                foreach (kickProf[i]) begin
                    motionQ.push_back(kickProf[i]);
                    hitQ.push_back(kickHit[i]);
                end
            end else begin
                mAct = (walkM != 0) ? 1 : 0;
            end
        end
        if (mAct >= 2 && mAct <= 4) begin
            m    = motionQ.pop_front();
            hitA = hitQ.pop_front();
            prof = 1'b1;
        end else if (mAct == 1 || mAct == 5) begin
            m = walkM;
        end else begin
            m = 0;
        end
        sum = xv + m;
        if (sum < MIN_X || sum > MAX_X) begin
            m = (sum < MIN_X) ? (MIN_X - xv) : (MAX_X - xv);
            if (prof) begin
                motionQ.delete();
                hitQ.delete();
            end
        end
        nxtMotion = m;
        nxtAct    = mAct;
        nxtHit    = hitA;
    endtask

    task automatic applyStimulus(input bit rn, input bit tk, input bit p, input bit k,
                                 input bit wl, input bit wr, input bit h, input bit hd,
                                 input int xv);
        Reset_n    = rn;
        frame_tick = tk;
        Punch      = p;
        Kick       = k;
        Walk_L     = wl;
        Walk_R     = wr;
        Hit        = h;
        Hit_Dir    = hd;
        Xpos       = xv;
        if (!rn)     modelReset();
        else if (tk) modelTick(p, k, wl, wr, h, hd, xv);
        @(posedge clk);
        #1;
        expMotion = nxtMotion;
        expAct    = nxtAct;
        expHit    = nxtHit;
    endtask

    // One tick followed by two idle cycles carrying junk requests that must be ignored.
    task automatic frame(input bit p, input bit k, input bit wl, input bit wr,
                         input bit h, input bit hd, input int xv);
        applyStimulus(1'b1, 1'b1, p, k, wl, wr, h, hd, xv);
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), xv);
        end
    endtask

    task automatic checkOutput();
        compareInt("motion", Ball_X_Motion, expMotion);
        compareInt("action", int'(Action), expAct);
        compareInt("busy", int'(Busy), (expAct >= 2 && expAct <= 4) ? 1 : 0);
        compareInt("hit_active", int'(Hit_Active), int'(expHit));
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    initial begin
        bit rn, tk, p, k, wl, wr, h, hd;
        modelReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 100);
        checkEn = 1'b1;
        pinCheck("rst_motion", Ball_X_Motion, expMotion, 0);
        pinCheck("rst_action", int'(Action), expAct, 0);

        $display("[TB] punch profile at x=100");
        frame(1, 0, 0, 0, 0, 0, 100);
        pinCheck("punch_f1", Ball_X_Motion, expMotion, -7);
        frame(0, 0, 0, 0, 0, 0, 100);
        frame(0, 0, 0, 0, 0, 0, 100);
        pinCheck("punch_f3_hit", int'(Hit_Active), int'(expHit), 1);
        repeat (3) frame(0, 0, 0, 0, 0, 0, 100);
        pinCheck("punch_f6", Ball_X_Motion, expMotion, -3);
        frame(0, 0, 0, 0, 0, 0, 100);
        pinCheck("cool_entry", int'(Action), expAct, 5);
        repeat (3) frame(0, 0, 0, 0, 0, 0, 100);
        pinCheck("cool_last", int'(Action), expAct, 5);
        frame(0, 0, 0, 0, 0, 0, 100);
        pinCheck("cool_done", int'(Action), expAct, 0);

        $display("[TB] punch clamped at left wall");
        frame(1, 0, 0, 0, 0, 0, 10);
        pinCheck("clamp_punch", Ball_X_Motion, expMotion, -3);
        frame(0, 0, 0, 0, 0, 0, 7);
        pinCheck("clamp_end", int'(Action), expAct, 5);
        repeat (4) frame(0, 0, 0, 0, 0, 0, 7);

        $display("[TB] knockback interrupts punch");
        repeat (3) frame(1, 0, 0, 0, 0, 0, 200);
        frame(0, 0, 0, 0, 1, 1, 200);
        pinCheck("knock_f1", Ball_X_Motion, expMotion, 6);
        repeat (6) frame(0, 0, 0, 0, 0, 0, 200);
        frame(0, 0, 0, 0, 0, 0, 200);
        pinCheck("knock_f8", Ball_X_Motion, expMotion, 1);
        frame(0, 0, 0, 0, 0, 0, 200);
        pinCheck("knock_end", int'(Action), expAct, 0);

        $display("[TB] punch+kick priority and walking cooldown");
        frame(1, 1, 0, 0, 0, 0, 300);
        pinCheck("pk_prio", int'(Action), expAct, 2);
        repeat (5) frame(0, 0, 0, 0, 0, 0, 300);
        frame(0, 1, 0, 1, 0, 0, 300);
        pinCheck("cool_walk", Ball_X_Motion, expMotion, 2);
        repeat (3) frame(0, 1, 0, 1, 0, 0, 300);
        pinCheck("cool_kick_ign", int'(Action), expAct, 5);
        frame(0, 0, 0, 0, 0, 0, 300);

        $display("[TB] walking into right wall");
        frame(0, 0, 0, 1, 0, 0, 631);
        pinCheck("walk_clamp", Ball_X_Motion, expMotion, 1);
        frame(0, 0, 0, 1, 0, 0, 632);
        pinCheck("walk_wall", Ball_X_Motion, expMotion, 0);
        frame(0, 0, 1, 1, 0, 0, 300);
        pinCheck("walk_both", int'(Action), expAct, 0);

        $display("[TB] reset mid-kick with tick");
        frame(0, 1, 0, 0, 0, 0, 300);
        frame(0, 0, 0, 0, 0, 0, 300);
        applyStimulus(1'b0, 1'b1, 1, 1, 0, 1, 1, 1, 300);
        pinCheck("rst_mid_motion", Ball_X_Motion, expMotion, 0);
        pinCheck("rst_mid_busy", int'(Busy), (expAct >= 2 && expAct <= 4) ? 1 : 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 300);

        $display("[TB] randomized traffic");
        x = 300;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 299) != 0);
            tk = ($urandom_range(0, 2) == 0);
            p  = ($urandom_range(0, 7) == 0);
            k  = ($urandom_range(0, 7) == 0);
            wl = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 15) == 0);
            hd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) x = int'($urandom_range(0, 680)) - 20;
            applyStimulus(rn, tk, p, k, wl, wr, h, hd, x);
            if (rn && tk) x = x + expMotion;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/p1_action_sequencer.md
# p1_action_sequencer

Per-frame action controller for player 1. It arbitrates the move requests (knockback, punch, kick, walk) onto the single horizontal-motion output that drives the player sprite position logic. It steps fixed motion profiles one frame at a time and clamps every step against the arena walls. It also raises the hitbox-active flag on the striking frames and enforces an attack cooldown.

## Interface
Parameters:
- BOUND_X_MIN, 7, left wall X coordinate
- BOUND_X_MAX, 632, right wall X coordinate
- COOLDOWN, 4, idle frames forced after a punch or kick

Ports:
- clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle strobe, one per video frame; all state advances only on tick cycles
- Punch, Kick  in  1  attack requests, level-sampled on ticks
- Walk_L, Walk_R  in  1  walk requests, level-sampled on ticks
- Hit  in  1  player was struck, sampled on ticks
- Hit_Dir  in  1  knockback direction: 0 = left (negative), 1 = right (positive)
- Xpos  in  32 signed  current player X
- Ball_X_Motion  out  32 signed  X delta for this frame
- Action  out  3  0 IDLE, 1 WALK, 2 PUNCH, 3 KICK, 4 KNOCK, 5 COOLDOWN
- Busy  out  1  high while Action is PUNCH, KICK or KNOCK
- Hit_Active  out  1  attack hitbox enable

## Operation
- State: an action register, a 4-bit step index and a cooldown counter.
- Motion profiles, indexed by step:
  - PUNCH: -7, -7, -5, -5, -3, -3
  - KICK: -4, -4, -4, -4, 0, 0, 0, 0
  - KNOCK: magnitudes 6, 6, 4, 4, 2, 2, 1, 1, signed by Hit_Dir as latched at entry
  - WALK: -2 for Walk_L, +2 for Walk_R; both high gives 0 and IDLE
- Hit_Active is high on PUNCH steps 2–3 and KICK steps 4–5; it is low otherwise.
- Priority on every tick, highest first:
  - Hit: enter KNOCK at step 0 from any state, including mid-attack, during KNOCK (restart) and during COOLDOWN.
  - While PUNCH, KICK or KNOCK is running: continue the profile. Punch, Kick and Walk are ignored.
  - From IDLE or WALK: Punch, then Kick, then Walk. Punch and Kick both high selects PUNCH.
  - In COOLDOWN: Punch and Kick are ignored. Walk is still honoured, but Action stays 5 until the counter expires.
- Profile end:
  - After the last step, PUNCH and KICK go to COOLDOWN with the counter set to COOLDOWN, then to IDLE. COOLDOWN outputs motion 0, or ±2 when walking.
  - KNOCK goes to IDLE with no cooldown.
- Wall clamp, applied to every candidate step m in 32-bit signed arithmetic:
  - If Xpos + m < BOUND_X_MIN, output BOUND_X_MIN - Xpos.
  - If Xpos + m > BOUND_X_MAX, output BOUND_X_MAX - Xpos.
  - A clamped PUNCH, KICK or KNOCK step terminates the profile: the next tick takes the normal end transition (COOLDOWN or IDLE).
  - A clamped WALK step does not change state.
  - If Xpos is already outside the bounds, the clamp formula pulls the player back inside. This is intentional.

## Timing
- Reset: when Reset_n is low at a clk edge:
  - Action = 0, step = 0, cooldown = 0.
  - Ball_X_Motion = 0, Busy = 0, Hit_Active = 0.
  - Reset overrides frame_tick, applies mid-profile, and discards any latched Hit_Dir.
- On a tick cycle the block samples the request inputs and Xpos, computes the transition and the clamped step, and registers Ball_X_Motion, Action, Busy and Hit_Active.
- New values are visible the cycle after the tick and are held unchanged until the next tick.
- Latency: a request sampled on tick N produces its first step on the output after tick N, as the first frame of the action. There is no extra frame delay.
- Requests are not latched. A request must be high on a tick cycle to register.
- A tick that arrives while Reset_n is low has no effect beyond the reset.

## Test plan
- Reset, Xpos=100, Punch high on one tick, then ticks with no requests → motion -7, -7, -5, -5, -3, -3. Hit_Active is high on frames 3–4. Then 4 frames of 0 with Action=5, then Action=0.
- Xpos=10, Punch → first motion -3 (clamped). Next tick Action=5.
- Punch started at Xpos=200; Hit with Hit_Dir=1 on the tick after step 2 → motion sequence switches to +6, +6, +4, +4, +2, +2, +1, +1, then IDLE with no cooldown.
- IDLE, Punch and Kick both high → PUNCH profile. During COOLDOWN, Kick is ignored and Walk_R gives +2 per frame.
- Walk_R held at Xpos=631 → +1 (clamped), then 0 once Xpos=632. Walk_L and Walk_R together → 0, Action=0.
- Reset_n low mid-kick with frame_tick high → next cycle all outputs are 0. Gaps between ticks hold the outputs steady.
